result_monitor: RTL

RESULT_MONITOR -- requirements
Module: result_monitor

---
 rtl/result_monitor_pkg.sv | 15 +
 rtl/result_exp_gen.sv | 50 +++++
 rtl/result_monitor.sv | 124 ++++++++++++
 3 files changed

// File: rtl/result_monitor_pkg.sv
// Shared definitions for the result monitor: controller states and
// expected-value generation modes.
package result_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        REPORT
    } state_t;

    localparam int MODE_ASC   = 0;
    localparam int MODE_DESC  = 1;
    localparam int MODE_TABLE = 2;

endpackage

// File: rtl/result_exp_gen.sv
// Expected-value source for the result monitor: arithmetic sequence or a
// loaded table, read combinationally by index; END_SYM once idx reaches NUM_DATA.
module result_exp_gen
    import result_monitor_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_DATA  = 50,
    parameter int MODE      = 0,
    parameter int SEQ_START = 1,
    parameter int SEQ_STEP  = 1,
    parameter int END_SYM   = 'hD5D
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [7:0]        wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [7:0]        rd_idx,
    output logic [DATA_W-1:0] expected
);

    localparam int IW = (NUM_DATA > 1) ? $clog2(NUM_DATA) : 1;
    localparam logic [7:0]        LAST_IDX = 8'(NUM_DATA);
    localparam logic [DATA_W-1:0] START_V  = DATA_W'(SEQ_START);
    localparam logic [DATA_W-1:0] STEP_V   = DATA_W'(SEQ_STEP);
    localparam logic [DATA_W-1:0] END_V    = DATA_W'(END_SYM);

    // Not reset: a loaded table survives reset so a run can be repeated.
    logic [DATA_W-1:0] tbl_mem [NUM_DATA];
    logic [DATA_W-1:0] offs;

    always_ff @(posedge clk) begin
        if (wr_en && (wr_idx < LAST_IDX)) begin
            tbl_mem[IW'(wr_idx)] <= wr_data;
        end
    end

    assign offs = STEP_V * DATA_W'(rd_idx);

    always_comb begin
        expected = END_V;
        if (rd_idx < LAST_IDX) begin
            case (MODE)
                MODE_DESC:  expected = START_V - offs;
                MODE_TABLE: expected = tbl_mem[IW'(rd_idx)];
                default:    expected = START_V + offs;
            endcase
        end
    end

endmodule

// File: rtl/result_monitor.sv
// Watches bus writes to TEST_PORT, checks the data stream framed by
// BEGIN_SYM/END_SYM against expected values and reports the outcome.
module result_monitor
    import result_monitor_pkg::*;
#(
    parameter int          ADDR_W    = 30,
    parameter int          DATA_W    = 32,
    parameter int          TEST_PORT = 'h40,
    parameter int          BEGIN_SYM = 'h932,
    parameter int          END_SYM   = 'hD5D,
    parameter int          NUM_DATA  = 50,
    parameter int          MODE      = 0,
    parameter int          SEQ_START = 1,
    parameter int          SEQ_STEP  = 1,
    parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              wen,
    input  logic              exp_we,
    input  logic [7:0]        exp_idx,
    input  logic [DATA_W-1:0] exp_data,
    output logic [7:0]        error_num,
    output logic [15:0]       duration,
    output logic              finish,
    output logic              timeout,
    output logic              pass,
    output logic [7:0]        first_err_idx
);

    localparam logic [ADDR_W-1:0] PORT_A   = ADDR_W'(TEST_PORT);
    localparam logic [DATA_W-1:0] BEGIN_V  = DATA_W'(BEGIN_SYM);
    localparam logic [7:0]        LAST_IDX = 8'(NUM_DATA);

    state_t            state, state_n;
    logic              wen_d;
    logic [7:0]        idx, idx_n, err_n, fei_n;
    logic [15:0]       dur_n;
    logic              to_n;
    logic              hit;
    logic [DATA_W-1:0] expected;

    result_exp_gen #(
        .DATA_W   (DATA_W),
        .NUM_DATA (NUM_DATA),
        .MODE     (MODE),
        .SEQ_START(SEQ_START),
        .SEQ_STEP (SEQ_STEP),
        .END_SYM  (END_SYM)
    ) u_exp_gen (
        .clk     (clk),
        .wr_en   (exp_we && (state == IDLE)),
        .wr_idx  (exp_idx),
        .wr_data (exp_data),
        .rd_idx  (idx),
        .expected(expected)
    );

    // Rising edge of wen only, so a write held for several cycles counts once.
    assign hit    = wen && !wen_d && (addr == PORT_A);
    assign finish = (state == REPORT);
    assign pass   = finish && (error_num == '0) && !timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wen_d         <= 1'b0;
            error_num     <= '1;
            duration      <= '0;
            first_err_idx <= '0;
            idx           <= '0;
            timeout       <= 1'b0;
        end else begin
            state         <= state_n;
            wen_d         <= wen;
            error_num     <= err_n;
            duration      <= dur_n;
            first_err_idx <= fei_n;
            idx           <= idx_n;
            timeout       <= to_n;
        end
    end

    always_comb begin
        state_n = state;
        err_n   = error_num;
        dur_n   = duration;
        fei_n   = first_err_idx;
        idx_n   = idx;
        to_n    = timeout;
        case (state)
            IDLE: begin
                if (hit && (data == BEGIN_V)) begin
                    state_n = CHECK;
                    err_n   = '0;
                    dur_n   = '0;
                    fei_n   = '0;
                    idx_n   = '0;
                end
            end
            CHECK: begin
                // Duration freezes at TIMEOUT; a write landing on that cycle is still checked.
                if (duration == TIMEOUT) begin
                    state_n = REPORT;
                    to_n    = 1'b1;
                end else if (duration != '1) begin
                    dur_n = duration + 16'd1;
                end
                if (hit) begin
                    if (data != expected) begin
                        if (error_num == '0) fei_n = idx;
                        if (error_num != '1) err_n = error_num + 8'd1;
                    end
                    if (idx == LAST_IDX) state_n = REPORT;
                    else                 idx_n   = idx + 8'd1;
                end
            end
            default: ;
        endcase
    end

endmodule
